// File: rtl/pool_row_output_if.sv
// Pixel/result bundle between the row shifter side and the pooling consumer.
// The bench drives the master side; pool_row_output owns the slave side.
interface pool_row_output_if;
    logic       CE;
    logic [7:0] in;
    logic [7:0] in_row;
    logic [7:0] out;
    logic       out_valid;
    logic       frame_done;

    modport master (
        output CE, in, in_row,
        input  out, out_valid, frame_done
    );

    modport slave (
        input  CE, in, in_row,
        output out, out_valid, frame_done
    );
endinterface

// File: rtl/pool_row_output.sv
// 2x2 stride-2 max pooling over the live row and the one-row-delayed row.
// Emits one pooled value per window, with a frame_done pulse on the last window.
module pool_row_output #(
    parameter int ROW_LEN = 8,
    parameter int ROWS    = 8
) (
    input  logic              clk,
    input  logic              rst,
    pool_row_output_if.slave  bus
);
    localparam int CW = $clog2(ROW_LEN);
    localparam int RW = $clog2(ROWS);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        POOL_A = 2'd1,
        POOL_B = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [7:0]      r_hold;
    logic [7:0]      r_out;
    logic            r_out_valid;
    logic            r_frame_done;

    logic            w_last_col;
    logic            w_last_row;
    logic [7:0]      w_pair_max;

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    assign w_last_col = (r_col == CW'(ROW_LEN - 1));
    assign w_last_row = (r_row == RW'(ROWS - 1));
    assign w_pair_max = max8(bus.in, bus.in_row);

    // Pixel counters, window FSM and registered pooled outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FILL;
            r_col        <= '0;
            r_row        <= '0;
            r_hold       <= 8'd0;
            r_out        <= 8'd0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // Pulses are cleared every edge so a CE gap can never stretch them.
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            if (bus.CE) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                case (r_state)
                    FILL: begin
                        r_state <= w_last_col ? POOL_A : FILL;
                    end
                    POOL_A: begin
                        r_hold  <= w_pair_max;
                        r_state <= POOL_B;
                    end
                    POOL_B: begin
                        r_out        <= max8(r_hold, w_pair_max);
                        r_out_valid  <= 1'b1;
                        r_frame_done <= w_last_col & w_last_row;
                        r_state      <= w_last_col ? FILL : POOL_A;
                    end
                    default: begin
                        r_state <= FILL;
                    end
                endcase
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign bus.out        = r_out;
    assign bus.out_valid  = r_out_valid;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_pool_row_output.sv
// Randomized self-checking bench for pool_row_output: a 4x2 instance for the
// directed window cases and a 4x4 instance for frame wrap and random frames.
module tb_pool_row_output;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pool_row_output_if ifa ();
    pool_row_output_if ifb ();

    pool_row_output #(.ROW_LEN(4), .ROWS(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    pool_row_output #(.ROW_LEN(4), .ROWS(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    logic [7:0] qa[$];
    logic       qa_fd[$];
    logic [7:0] qb[$];
    logic       qb_fd[$];
    int         stretch_a = 0, stretch_b = 0, orphan_fd = 0;
    logic       prev_va = 1'b0, prev_vb = 1'b0;
    logic [7:0] exp_b[$];
    logic       exp_fd_b[$];

    // Output monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (ifa.out_valid) begin
            qa.push_back(ifa.out);
            qa_fd.push_back(ifa.frame_done);
        end
        if (ifb.out_valid) begin
            qb.push_back(ifb.out);
            qb_fd.push_back(ifb.frame_done);
        end
        if (ifa.out_valid && prev_va) stretch_a++;
        if (ifb.out_valid && prev_vb) stretch_b++;
        if ((ifa.frame_done && !ifa.out_valid) || (ifb.frame_done && !ifb.out_valid)) orphan_fd++;
        prev_va = ifa.out_valid;
        prev_vb = ifb.out_valid;
    end

    task automatic send_a(input logic [7:0] p, input logic [7:0] r, input bit gap);
        @(negedge clk);
        ifa.CE = 1'b1; ifa.in = p; ifa.in_row = r;
        if (gap) begin
            @(negedge clk);
            ifa.CE = 1'b0; ifa.in = 8'($urandom); ifa.in_row = 8'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ifa.CE = 1'b0; ifb.CE = 1'b0;
        end
    endtask

    task automatic check_qa(input string name, input logic [7:0] e0, input logic [7:0] e1);
        tests++;
        if (qa.size() !== 2) begin
            fails++; $display("FAIL %s count: got %0d want 2", name, qa.size());
        end
        for (int i = 0; i < qa.size() && i < 2; i++) begin
            tests++;
            if (qa[i] !== ((i == 0) ? e0 : e1) || qa_fd[i] !== (i == 1)) begin
                fails++;
                $display("FAIL %s window %0d: got out=%0d fd=%b want out=%0d fd=%b", name, i, qa[i], qa_fd[i], (i == 0) ? e0 : e1, (i == 1));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.CE = 1'b0; ifb.CE = 1'b0;
        ifa.in = 8'd0; ifa.in_row = 8'd0; ifb.in = 8'd0; ifb.in_row = 8'd0;
        repeat (2) @(negedge clk);
        tests++;
        if ({ifa.out, ifa.out_valid, ifa.frame_done, ifb.out, ifb.out_valid, ifb.frame_done} !== 20'd0) begin
            fails++;
            $display("FAIL reset: got a=%0d/%b/%b b=%0d/%b/%b want all 0", ifa.out, ifa.out_valid, ifa.frame_done, ifb.out, ifb.out_valid, ifb.frame_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        qa.delete(); qa_fd.delete();
        for (int c = 0; c < 4; c++) send_a(8'(c + 1), 8'd0, 1'b0);
        for (int c = 0; c < 4; c++) send_a(8'(c + 5), 8'(c + 1), 1'b0);
        idle(3);
        check_qa("basic", 8'd6, 8'd8);
        tests++;
        if (ifa.out !== 8'd8) begin
            fails++; $display("FAIL basic hold: got %0d want 8", ifa.out);
        end
    endtask

    task automatic test_delayed_row();
        logic [7:0] rowv [4];
        rowv = '{8'd200, 8'd1, 8'd1, 8'd250};
        qa.delete(); qa_fd.delete();
        for (int c = 0; c < 4; c++) send_a(8'd0, 8'd0, 1'b0);
        for (int c = 0; c < 4; c++) send_a(8'd1, rowv[c], 1'b0);
        idle(3);
        check_qa("delayed_row", 8'd200, 8'd250);
    endtask

    task automatic test_ce_gaps();
        qa.delete(); qa_fd.delete();
        for (int c = 0; c < 4; c++) send_a(8'(c + 1), 8'd0, 1'b1);
        send_a(8'd5, 8'd1, 1'b1);
        send_a(8'd6, 8'd2, 1'b1);
        tests++;
        if (ifa.out_valid !== 1'b1 || ifa.out !== 8'd6) begin
            fails++; $display("FAIL gaps first window: got out=%0d v=%b want 6/1", ifa.out, ifa.out_valid);
        end
        @(negedge clk);
        tests++;
        if (ifa.out_valid !== 1'b0 || ifa.out !== 8'd6) begin
            fails++; $display("FAIL gaps hold: got out=%0d v=%b want 6/0", ifa.out, ifa.out_valid);
        end
        send_a(8'd7, 8'd3, 1'b1);
        send_a(8'd8, 8'd4, 1'b1);
        idle(3);
        check_qa("ce_gaps", 8'd6, 8'd8);
        tests++;
        if (stretch_a !== 0) begin
            fails++; $display("FAIL gaps stretch: got %0d stretched pulses want 0", stretch_a);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int c = 0; c < 4; c++) send_a(8'(c + 1), 8'd0, 1'b0);
        send_a(8'd77, 8'd99, 1'b0);
        @(negedge clk);
        ifa.CE = 1'b0;
        n = qa.size();
        rst = 1'b1;
        #1;
        tests++;
        if ({ifa.out, ifa.out_valid, ifa.frame_done} !== 10'd0) begin
            fails++; $display("FAIL reset_mid async: got out=%0d v=%b fd=%b want 0", ifa.out, ifa.out_valid, ifa.frame_done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ifa.CE = 1'b1; ifa.in = 8'd255; ifa.in_row = 8'd255;
        end
        @(negedge clk);
        ifa.CE = 1'b0;
        tests++;
        if (qa.size() !== n || ifa.out !== 8'd0) begin
            fails++; $display("FAIL reset_mid stray: got %0d pulses out=%0d want 0 pulses out=0", qa.size() - n, ifa.out);
        end
        rst = 1'b0;
        qa.delete(); qa_fd.delete();
        for (int c = 0; c < 4; c++) send_a(8'(c + 1), 8'd0, 1'b0);
        for (int c = 0; c < 4; c++) send_a(8'(c + 5), 8'(c + 1), 1'b0);
        idle(3);
        check_qa("reset_mid", 8'd6, 8'd8);
    endtask

    // Random 4x4 frame: expected windows taken straight from the pixel arrays.
    task automatic send_frame_b(input bit gaps);
        logic [7:0] pin [4][4];
        logic [7:0] prow [4][4];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                pin[r][c]  = 8'($urandom);
                prow[r][c] = 8'($urandom);
            end
        for (int wr = 0; wr < 2; wr++)
            for (int wc = 0; wc < 2; wc++) begin
                logic [7:0] m;
                m = 8'd0;
                for (int dc = 0; dc < 2; dc++) begin
                    if (pin[2*wr+1][2*wc+dc] > m)  m = pin[2*wr+1][2*wc+dc];
                    if (prow[2*wr+1][2*wc+dc] > m) m = prow[2*wr+1][2*wc+dc];
                end
                exp_b.push_back(m);
                exp_fd_b.push_back(wr == 1 && wc == 1);
            end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                ifb.CE = 1'b1; ifb.in = pin[r][c]; ifb.in_row = prow[r][c];
                if (gaps && $urandom_range(0, 1) == 1) begin
                    for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                        @(negedge clk);
                        ifb.CE = 1'b0; ifb.in = 8'($urandom); ifb.in_row = 8'($urandom);
                    end
                end
            end
    endtask

    task automatic compare_b(input string name, input int nframes);
        int nfd;
        nfd = 0;
        foreach (qb_fd[i]) if (qb_fd[i]) nfd++;
        tests++;
        if (qb.size() !== 4 * nframes || nfd !== nframes) begin
            fails++; $display("FAIL %s counts: got %0d pulses %0d frame_done want %0d/%0d", name, qb.size(), nfd, 4 * nframes, nframes);
        end
        for (int i = 0; i < qb.size() && i < exp_b.size(); i++) begin
            tests++;
            if (qb[i] !== exp_b[i] || qb_fd[i] !== exp_fd_b[i]) begin
                fails++; $display("FAIL %s window %0d: got %0d fd=%b want %0d fd=%b", name, i, qb[i], qb_fd[i], exp_b[i], exp_fd_b[i]);
            end
        end
        qb.delete(); qb_fd.delete(); exp_b.delete(); exp_fd_b.delete();
    endtask

    task automatic test_frame_wrap();
        qb.delete(); qb_fd.delete(); exp_b.delete(); exp_fd_b.delete();
        send_frame_b(1'b0);
        send_frame_b(1'b0);
        idle(3);
        compare_b("frame_wrap", 2);
    endtask

    task automatic test_random_gaps();
        for (int f = 0; f < 4; f++) send_frame_b(1'b1);
        idle(3);
        compare_b("random_gaps", 4);
        tests++;
        if (stretch_b !== 0 || orphan_fd !== 0) begin
            fails++; $display("FAIL pulse shape: got %0d stretched %0d orphan frame_done want 0/0", stretch_b, orphan_fd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delayed_row();
        test_ce_gaps();
        test_reset_mid();
        test_frame_wrap();
        test_random_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
